sd_data_xfer_ctrl: RTL and testbench

Multi-block transfer sequencer that sits between the SD controller register/command layer and the 4-bit serial data engine. For one transfer command it issues N single-block read or write requests to the engine through the engine's start/finish handshake. Between blocks it checks buffer readiness, enforces an inter-block gap and runs a per-block watchdog. It evaluates each block's CRC/status result, stops on the first error or on abort, and reports block count and error status.

---
 rtl/sd_data_xfer_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_sd_data_xfer_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_data_xfer_ctrl.sv
// Multi-block SD data transfer sequencer: issues per-block start requests to the data engine,
// checks block status, enforces inter-block gaps, runs a per-block watchdog and handles abort.
module sd_data_xfer_ctrl #(
    parameter int unsigned BLKCNT_W     = 16,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned ABORT_CYCLES = 2
) (
    input  logic                sd_clk,
    input  logic                rst,
    input  logic                go_i,
    input  logic                dir_i,
    input  logic [BLKCNT_W-1:0] blkcnt_i,
    input  logic                bus_4bit_i,
    input  logic [31:0]         wdog_limit_i,
    input  logic                abort_i,
    input  logic                buf_ready_i,
    output logic [1:0]          start_o,
    input  logic                finish_i,
    input  logic [4:0]          crc_s_i,
    input  logic [3:0]          crc_lane_ok_i,
    output logic                xfer_busy_o,
    output logic                xfer_done_o,
    output logic [BLKCNT_W-1:0] blk_done_o,
    output logic [2:0]          err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitBuf,
        StIssue,
        StRelease,
        StGap,
        StAbort,
        StDone
    } state_e;

    localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned AbortW = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;
    localparam logic [GapW-1:0]   GapLoad   = GapW'(GAP_CYCLES - 1);
    localparam logic [AbortW-1:0] AbortLoad = AbortW'(ABORT_CYCLES - 1);

    localparam logic [1:0] StartIdle  = 2'b00;
    localparam logic [1:0] StartWrite = 2'b01;
    localparam logic [1:0] StartRead  = 2'b10;
    localparam logic [1:0] StartAbort = 2'b11;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [1:0]            r_start;
    logic [1:0]            w_start_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic [BLKCNT_W-1:0]   r_blk_done;
    logic [BLKCNT_W-1:0]   w_blk_done_nxt;
    logic [2:0]            r_err;
    logic [2:0]            w_err_nxt;
    logic                  r_dir;
    logic                  w_dir_nxt;
    logic                  r_bus4;
    logic                  w_bus4_nxt;
    logic [BLKCNT_W-1:0]   r_blkcnt;
    logic [BLKCNT_W-1:0]   w_blkcnt_nxt;
    logic [31:0]           r_wdog;
    logic [31:0]           w_wdog_nxt;
    logic [GapW-1:0]       r_gap;
    logic [GapW-1:0]       w_gap_nxt;
    logic [AbortW-1:0]     r_abort_cnt;
    logic [AbortW-1:0]     w_abort_cnt_nxt;

    logic                  w_abort_req;
    logic                  w_wdog_exp;
    logic [3:0]            w_lane_mask;
    logic                  w_blk_pass;
    logic                  w_unused;

    // Bit 4 of the CRC-status capture is the start bit and carries no status.
    assign w_unused = crc_s_i[4];

    assign w_abort_req = abort_i && (r_state != StIdle) && (r_state != StAbort)
                         && (r_state != StDone);
    assign w_wdog_exp  = (r_wdog >= wdog_limit_i);
    assign w_lane_mask = r_bus4 ? 4'hF : 4'h1;
    assign w_blk_pass  = r_dir ? ((crc_lane_ok_i & w_lane_mask) == w_lane_mask)
                               : ((crc_s_i[3:1] == 3'b010) && crc_s_i[0]);

    always_ff @(posedge sd_clk) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_start     <= StartIdle;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_blk_done  <= '0;
            r_err       <= '0;
            r_dir       <= 1'b0;
            r_bus4      <= 1'b0;
            r_blkcnt    <= '0;
            r_wdog      <= '0;
            r_gap       <= '0;
            r_abort_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_start     <= w_start_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_blk_done  <= w_blk_done_nxt;
            r_err       <= w_err_nxt;
            r_dir       <= w_dir_nxt;
            r_bus4      <= w_bus4_nxt;
            r_blkcnt    <= w_blkcnt_nxt;
            r_wdog      <= w_wdog_nxt;
            r_gap       <= w_gap_nxt;
            r_abort_cnt <= w_abort_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort_req) begin
            w_state_nxt = StAbort;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (go_i) begin
                        w_state_nxt = (blkcnt_i == '0) ? StDone : StWaitBuf;
                    end
                end
                StWaitBuf: begin
                    if (buf_ready_i) begin
                        w_state_nxt = StIssue;
                    end
                end
                StIssue: begin
                    // A finishing block beats a watchdog expiry in the same cycle.
                    if (finish_i) begin
                        w_state_nxt = StRelease;
                    end else if (w_wdog_exp) begin
                        w_state_nxt = StAbort;
                    end
                end
                StRelease: begin
                    if (r_err[0] || (r_blk_done == r_blkcnt)) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_state_nxt = StGap;
                    end
                end
                StGap: begin
                    if (r_gap == '0) begin
                        w_state_nxt = StWaitBuf;
                    end
                end
                StAbort: begin
                    if (r_abort_cnt == '0) begin
                        w_state_nxt = StDone;
                    end
                end
                StDone: begin
                    w_state_nxt = StIdle;
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        w_start_nxt     = r_start;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_blk_done_nxt  = r_blk_done;
        w_err_nxt       = r_err;
        w_dir_nxt       = r_dir;
        w_bus4_nxt      = r_bus4;
        w_blkcnt_nxt    = r_blkcnt;
        w_wdog_nxt      = r_wdog;
        w_gap_nxt       = r_gap;
        w_abort_cnt_nxt = r_abort_cnt;

        if (w_abort_req) begin
            w_err_nxt[2]    = 1'b1;
            w_start_nxt     = StartAbort;
            w_abort_cnt_nxt = AbortLoad;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_start_nxt = StartIdle;
                    if (go_i) begin
                        w_dir_nxt      = dir_i;
                        w_bus4_nxt     = bus_4bit_i;
                        w_blkcnt_nxt   = blkcnt_i;
                        w_blk_done_nxt = '0;
                        w_err_nxt      = '0;
                        w_busy_nxt     = 1'b1;
                    end
                end
                StWaitBuf: begin
                    w_start_nxt = StartIdle;
                    if (buf_ready_i) begin
                        w_start_nxt = r_dir ? StartRead : StartWrite;
                        w_wdog_nxt  = '0;
                    end
                end
                StIssue: begin
                    if (r_wdog != '1) begin
                        w_wdog_nxt = r_wdog + 32'd1;
                    end
                    if (finish_i) begin
                        if (w_blk_pass) begin
                            w_blk_done_nxt = r_blk_done + 1'b1;
                        end else begin
                            w_err_nxt[0] = 1'b1;
                        end
                        w_start_nxt = StartIdle;
                    end else if (w_wdog_exp) begin
                        w_err_nxt[1]    = 1'b1;
                        w_start_nxt     = StartAbort;
                        w_abort_cnt_nxt = AbortLoad;
                    end
                end
                StRelease: begin
                    w_start_nxt = StartIdle;
                    w_gap_nxt   = GapLoad;
                end
                StGap: begin
                    w_start_nxt = StartIdle;
                    if (r_gap != '0) begin
                        w_gap_nxt = r_gap - 1'b1;
                    end
                end
                StAbort: begin
                    if (r_abort_cnt == '0) begin
                        w_start_nxt = StartIdle;
                    end else begin
                        w_abort_cnt_nxt = r_abort_cnt - 1'b1;
                    end
                end
                StDone: begin
                    w_start_nxt = StartIdle;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
                default: begin
                    w_start_nxt = StartIdle;
                end
            endcase
        end
    end

    assign start_o     = r_start;
    assign xfer_busy_o = r_busy;
    assign xfer_done_o = r_done;
    assign blk_done_o  = r_blk_done;
    assign err_o       = r_err;

endmodule

// File: tb/tb_sd_data_xfer_ctrl.sv
// Scoreboard bench for sd_data_xfer_ctrl: stimulus queues the expected per-transfer summary,
// a monitor observes start_o / xfer_done_o and compares when each transfer ends.
module tb_sd_data_xfer_ctrl;

    localparam int BW = 16;
    localparam int NoGap = 999;

    typedef struct {
        int blk;
        int err;
        int starts;
        int aborts;
        int min_gap;
        int max_issue;
    } exp_t;

    logic          sd_clk = 1'b0;
    logic          rst = 1'b0;
    logic          go_i = 1'b0;
    logic          dir_i = 1'b0;
    logic [BW-1:0] blkcnt_i = '0;
    logic          bus_4bit_i = 1'b0;
    logic [31:0]   wdog_limit_i = 32'd1000;
    logic          abort_i = 1'b0;
    logic          buf_ready_i = 1'b1;
    logic [1:0]    start_o;
    logic          finish_i = 1'b0;
    logic [4:0]    crc_s_i = '0;
    logic [3:0]    crc_lane_ok_i = '0;
    logic          xfer_busy_o;
    logic          xfer_done_o;
    logic [BW-1:0] blk_done_o;
    logic [2:0]    err_o;

    int n_checks = 0;
    int n_errors = 0;
    exp_t exp_q[$];

    // Engine model configuration
    int         eng_lat = 3;
    bit         eng_hang = 1'b0;
    logic [4:0] eng_crc [4];
    logic [3:0] eng_lane[4];
    int         eng_cnt = 0;
    int         eng_blk = 0;

    // Monitor state
    int         mon_starts = 0;
    int         mon_aborts = 0;
    int         mon_zero_run = 0;
    int         mon_min_gap = NoGap;
    int         mon_issue_run = 0;
    int         mon_max_issue = 0;
    int         done_seen = 0;
    logic [1:0] mon_prev = 2'b00;
    exp_t       mon_e;

    sd_data_xfer_ctrl #(
        .BLKCNT_W    (BW),
        .GAP_CYCLES  (4),
        .ABORT_CYCLES(2)
    ) dut (
        .sd_clk       (sd_clk),
        .rst          (rst),
        .go_i         (go_i),
        .dir_i        (dir_i),
        .blkcnt_i     (blkcnt_i),
        .bus_4bit_i   (bus_4bit_i),
        .wdog_limit_i (wdog_limit_i),
        .abort_i      (abort_i),
        .buf_ready_i  (buf_ready_i),
        .start_o      (start_o),
        .finish_i     (finish_i),
        .crc_s_i      (crc_s_i),
        .crc_lane_ok_i(crc_lane_ok_i),
        .xfer_busy_o  (xfer_busy_o),
        .xfer_done_o  (xfer_done_o),
        .blk_done_o   (blk_done_o),
        .err_o        (err_o)
    );

    always #5 sd_clk = ~sd_clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge sd_clk);
    endtask

    // Engine: raises finish eng_lat cycles into a block request and holds it until start drops.
    initial begin
        forever begin
            @(negedge sd_clk);
            if (start_o == 2'b01 || start_o == 2'b10) begin
                eng_cnt++;
                if (!eng_hang && eng_cnt >= eng_lat) begin
                    finish_i      = 1'b1;
                    crc_s_i       = eng_crc[eng_blk & 3];
                    crc_lane_ok_i = eng_lane[eng_blk & 3];
                end
            end else begin
                if (eng_cnt > 0) eng_blk++;
                eng_cnt  = 0;
                finish_i = 1'b0;
                if (!xfer_busy_o) eng_blk = 0;
            end
        end
    end

    // Monitor: summarises each transfer and compares against the scoreboard on xfer_done_o.
    initial begin
        forever begin
            @(negedge sd_clk);
            if (start_o == 2'b01 || start_o == 2'b10) begin
                if (mon_prev != start_o) begin
                    mon_starts++;
                    if (mon_starts > 1 && mon_zero_run < mon_min_gap) mon_min_gap = mon_zero_run;
                end
                mon_issue_run++;
                if (mon_issue_run > mon_max_issue) mon_max_issue = mon_issue_run;
            end else begin
                mon_issue_run = 0;
            end
            if (start_o == 2'b00) mon_zero_run++;
            else mon_zero_run = 0;
            if (start_o == 2'b11) mon_aborts++;
            mon_prev = start_o;

            if (xfer_done_o) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got xfer_done_o=1, expected no transfer end");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("blk_done", int'(blk_done_o), mon_e.blk);
                    check("err", int'(err_o), mon_e.err);
                    check("starts", mon_starts, mon_e.starts);
                    check("abort_cycles", mon_aborts, mon_e.aborts);
                    check("min_gap", mon_min_gap, mon_e.min_gap);
                    check("max_issue", mon_max_issue, mon_e.max_issue);
                    check("busy_at_done", int'(xfer_busy_o), 0);
                end
            end
            if (!xfer_busy_o) begin
                mon_starts    = 0;
                mon_aborts    = 0;
                mon_zero_run  = 0;
                mon_min_gap   = NoGap;
                mon_issue_run = 0;
                mon_max_issue = 0;
            end
        end
    end

    task automatic launch(input bit dir, input int cnt, input bit b4, input bit push,
                          input exp_t e);
        if (push) exp_q.push_back(e);
        dir_i      = dir;
        blkcnt_i   = BW'(cnt);
        bus_4bit_i = b4;
        go_i       = 1'b1;
        tick();
        go_i       = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int base;
        bit seen;
        base = done_seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_seen > base) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no xfer_done_o in %0d cycles, expected one", name,
                     budget);
        end
        tick();
        tick();
    endtask

    task automatic wait_start(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (start_o == 2'b01 || start_o == 2'b10) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got start_o=%0d, expected a block start", name, start_o);
        end
    endtask

    task automatic wait_idle_start(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (start_o == 2'b00) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got start_o=%0d, expected 0", name, start_o);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of stimulus, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int nz;
        for (int i = 0; i < 4; i++) begin
            eng_crc[i]  = 5'b00101;
            eng_lane[i] = 4'hF;
        end

        // Reset values
        tick(); tick(); tick();
        check("rst_start", int'(start_o), 0);
        check("rst_busy", int'(xfer_busy_o), 0);
        check("rst_done", int'(xfer_done_o), 0);
        check("rst_blk_done", int'(blk_done_o), 0);
        check("rst_err", int'(err_o), 0);
        rst = 1'b1;
        tick(); tick();

        // T1: write, 3 blocks, all good CRC tokens
        eng_lat = 3;
        launch(1'b0, 3, 1'b0, 1'b1, '{blk: 3, err: 0, starts: 3, aborts: 0, min_gap: 6,
                                     max_issue: 3});
        wait_done("t1", 300);

        // T2: read 4-bit, second block has a lane mismatch
        eng_lane[0] = 4'hF;
        eng_lane[1] = 4'b1011;
        launch(1'b1, 2, 1'b1, 1'b1, '{blk: 1, err: 1, starts: 2, aborts: 0, min_gap: 6,
                                     max_issue: 3});
        wait_done("t2", 300);

        // abort in IDLE must not start anything
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        tick(); tick();
        check("idle_abort_busy", int'(xfer_busy_o), 0);

        // T3: read 1-bit, lane0 only good; finish coincides with watchdog limit
        eng_lane[0]  = 4'b0001;
        wdog_limit_i = 32'd2;
        launch(1'b1, 1, 1'b0, 1'b1, '{blk: 1, err: 0, starts: 1, aborts: 0, min_gap: NoGap,
                                     max_issue: 3});
        wait_done("t3", 300);

        // T4: watchdog timeout, engine never finishes
        wdog_limit_i = 32'd100;
        eng_hang     = 1'b1;
        launch(1'b0, 1, 1'b0, 1'b1, '{blk: 0, err: 2, starts: 1, aborts: 2, min_gap: NoGap,
                                     max_issue: 101});
        wait_done("t4", 400);
        eng_hang     = 1'b0;
        wdog_limit_i = 32'd1000;

        // T5: abort mid second block of 4; a go during the transfer is ignored
        eng_lat = 10;
        launch(1'b0, 4, 1'b0, 1'b1, '{blk: 1, err: 4, starts: 2, aborts: 2, min_gap: 6,
                                     max_issue: 10});
        wait_start("t5_blk1", 50);
        tick(); tick();
        blkcnt_i = '0;
        go_i     = 1'b1;
        tick();
        go_i     = 1'b0;
        wait_idle_start("t5_rel", 50);
        wait_start("t5_blk2", 50);
        tick(); tick(); tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        wait_done("t5", 300);

        // T6: blkcnt=0 ends two cycles after go without a start
        go_i       = 1'b1;
        exp_q.push_back('{blk: 0, err: 0, starts: 0, aborts: 0, min_gap: NoGap, max_issue: 0});
        blkcnt_i   = '0;
        tick();
        go_i = 1'b0;
        check("zero_blk_busy_c1", int'(xfer_busy_o), 1);
        check("zero_blk_done_c1", int'(xfer_done_o), 0);
        tick();
        check("zero_blk_done_c2", int'(xfer_done_o), 1);
        tick(); tick();

        // T7: buffer not ready for 50 cycles before block 2
        eng_lat = 3;
        launch(1'b0, 3, 1'b0, 1'b1, '{blk: 3, err: 0, starts: 3, aborts: 0, min_gap: 6,
                                     max_issue: 3});
        wait_start("t7_blk1", 50);
        buf_ready_i = 1'b0;
        wait_idle_start("t7_rel", 50);
        nz = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (start_o != 2'b00) nz++;
        end
        check("bufwait_starts", nz, 0);
        buf_ready_i = 1'b1;
        wait_done("t7", 300);

        // T8: reset during ISSUE, no done pulse afterwards
        eng_lat = 10;
        launch(1'b0, 2, 1'b0, 1'b0, '{blk: 0, err: 0, starts: 0, aborts: 0, min_gap: 0,
                                     max_issue: 0});
        wait_start("t8_blk1", 50);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_start", int'(start_o), 0);
        check("midrst_busy", int'(xfer_busy_o), 0);
        check("midrst_done", int'(xfer_done_o), 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("midrst_idle_start", int'(start_o), 0);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
